mem_access: RTL and testbench

// - MEM stage of the RV32I pipeline; sits between ex_mem and mem_wb.
// - Executes loads/stores byte-serially through the memory controller, which has an
//   8-bit data port. Passes non-memory results straight through.
// - Holds the pipeline via stall_req until the access completes; drives mem_rd_* into mem_wb.

---
 rtl/mem_access_pkg.sv | 37 +++
 rtl/mem_load_ext.sv | 27 ++
 rtl/mem_access.sv | 184 ++++++++++++++++++
 tb/tb_mem_access.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants and helpers for the MEM stage.
// - funct3 encodings for loads/stores
// - FSM state encodings
// - op_valid / last_idx helpers used to decode the access size
package mem_access_pkg;

    localparam int unsigned REG_LEN = 32;

    // funct3 load/store encodings
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    function automatic logic op_valid(input logic [2:0] op);
        case (op)
            LS_B, LS_H, LS_W, LS_BU, LS_HU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Index of the final byte of an access (nbytes - 1).
    function automatic logic [1:0] last_idx(input logic [2:0] op);
        case (op)
            LS_B, LS_BU: return 2'd0;
            LS_H, LS_HU: return 2'd1;
            default:     return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result extension: turns the assembled little-endian byte buffer into the
// architectural load value.
// Ports:
//   word_i  in  32  assembled load bytes (byte 0 in [7:0])
//   op_i    in  3   funct3 of the load
//   data_o  out 32  sign/zero-extended result
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [REG_LEN-1:0] word_i,
    input  logic [2:0]         op_i,
    output logic [REG_LEN-1:0] data_o
);

    always_comb begin
        data_o = '0;
        case (op_i)
            LS_B:    data_o = {{24{word_i[7]}}, word_i[7:0]};
            LS_H:    data_o = {{16{word_i[15]}}, word_i[15:0]};
            LS_W:    data_o = word_i;
            LS_BU:   data_o = {24'd0, word_i[7:0]};
            LS_HU:   data_o = {16'd0, word_i[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the RV32I pipeline. Loads and stores are executed one byte at a
// time through an 8-bit memory controller port; non-memory results pass through
// combinationally. stall_req holds the upstream pipeline until the access ends.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ex_rd_*                  writeback data/register/enable from EX/MEM
//   ex_mem_load/store/op     access kind and funct3
//   ex_mem_addr/wdata        effective byte address and store data
//   mem_rd_*                 writeback data/register/enable to MEM/WB
//   stall_req                pipeline hold request
//   mc_req/we/addr/wdata     byte request to the memory controller
//   mc_ready/mc_rdata        byte completion pulse and read data
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_LEN-1:0]        ex_rd_data,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_rd_enable,
    input  logic                      ex_mem_load,
    input  logic                      ex_mem_store,
    input  logic [2:0]                ex_mem_op,
    input  logic [ADDR_WIDTH-1:0]     ex_mem_addr,
    input  logic [REG_LEN-1:0]        ex_mem_wdata,
    output logic [REG_LEN-1:0]        mem_rd_data,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                      mem_rd_enable,
    output logic                      stall_req,
    output logic                      mc_req,
    output logic                      mc_we,
    output logic [ADDR_WIDTH-1:0]     mc_addr,
    output logic [7:0]                mc_wdata,
    input  logic                      mc_ready,
    input  logic [7:0]                mc_rdata
);

    logic [1:0]                state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [REG_LEN-1:0]        rbuf_q, rbuf_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [REG_LEN-1:0]        wdata_q, wdata_d;
    logic [2:0]                op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                      rd_en_q, rd_en_d;
    logic                      is_store_q, is_store_d;

    logic                      mem_op;
    logic [REG_LEN-1:0]        ext_data;
    logic [7:0]                wbyte;

    assign mem_op = ex_mem_load | ex_mem_store;

    mem_load_ext u_load_ext (
        .word_i (rbuf_q),
        .op_i   (op_q),
        .data_o (ext_data)
    );

    always_comb begin
        case (cnt_q)
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rbuf_d     = rbuf_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = rd_en_q;
        is_store_d = is_store_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && op_valid(ex_mem_op)) begin
                    addr_d     = ex_mem_addr;
                    wdata_d    = ex_mem_wdata;
                    op_d       = ex_mem_op;
                    rd_addr_d  = ex_rd_addr;
                    rd_en_d    = ex_rd_enable;
                    is_store_d = ex_mem_store;
                    cnt_d      = 2'd0;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mc_ready) begin
                    if (!is_store_q) begin
                        case (cnt_q)
                            2'd0:    rbuf_d[7:0]   = mc_rdata;
                            2'd1:    rbuf_d[15:8]  = mc_rdata;
                            2'd2:    rbuf_d[23:16] = mc_rdata;
                            default: rbuf_d[31:24] = mc_rdata;
                        endcase
                    end
                    if (cnt_q == last_idx(op_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. Gated by rst so every output reads 0 while reset is held,
    // including the combinational pass-through path.
    always_comb begin
        mem_rd_data   = '0;
        mem_rd_addr   = '0;
        mem_rd_enable = 1'b0;
        stall_req     = 1'b0;
        mc_req        = 1'b0;
        mc_we         = 1'b0;
        mc_addr       = '0;
        mc_wdata      = '0;
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_op) begin
                        // Illegal funct3 is dropped: no stall, no writeback.
                        stall_req = op_valid(ex_mem_op);
                    end else begin
                        mem_rd_data   = ex_rd_data;
                        mem_rd_addr   = ex_rd_addr;
                        mem_rd_enable = ex_rd_enable;
                    end
                end
                ST_ACCESS: begin
                    stall_req = 1'b1;
                    mc_req    = 1'b1;
                    mc_we     = is_store_q;
                    mc_addr   = addr_q + ADDR_WIDTH'(cnt_q);
                    mc_wdata  = wbyte;
                end
                ST_DONE: begin
                    if (!is_store_q) begin
                        mem_rd_data   = ext_data;
                        mem_rd_addr   = rd_addr_q;
                        mem_rd_enable = rd_en_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            rbuf_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= 3'd0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rbuf_q     <= rbuf_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            is_store_q <= is_store_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table of instructions applied in a loop,
// a byte-wide memory responder that checks every controller request against a
// queue of expected byte transactions, and a hand-written reset-abort sequence.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_rd_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_enable;
    logic        ex_mem_load;
    logic        ex_mem_store;
    logic [2:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_wdata;
    logic [31:0] mem_rd_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_enable;
    logic        stall_req;
    logic        mc_req;
    logic        mc_we;
    logic [31:0] mc_addr;
    logic [7:0]  mc_wdata;
    logic        mc_ready;
    logic [7:0]  mc_rdata;

    mem_access #(
        .ADDR_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_rd_data    (ex_rd_data),
        .ex_rd_addr    (ex_rd_addr),
        .ex_rd_enable  (ex_rd_enable),
        .ex_mem_load   (ex_mem_load),
        .ex_mem_store  (ex_mem_store),
        .ex_mem_op     (ex_mem_op),
        .ex_mem_addr   (ex_mem_addr),
        .ex_mem_wdata  (ex_mem_wdata),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_enable (mem_rd_enable),
        .stall_req     (stall_req),
        .mc_req        (mc_req),
        .mc_we         (mc_we),
        .mc_addr       (mc_addr),
        .mc_wdata      (mc_wdata),
        .mc_ready      (mc_ready),
        .mc_rdata      (mc_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rd_en;
        logic        preload;
        logic [31:0] init;
        int          delay;
        logic [31:0] exp_data;
        logic [4:0]  exp_addr;
        logic        exp_en;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } mc_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        en;
    } rd_exp_t;

    mc_exp_t    mc_q[$];
    rd_exp_t    rd_q[$];
    logic [7:0] mem [logic [31:0]];
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         mem_delay = 0;
    int         hs_count  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    function automatic int nbytes_of(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic legal(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
               (op == 3'b100) || (op == 3'b101);
    endfunction

    task automatic push_bytes(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                              input int n);
        mc_exp_t e;
        for (int b = 0; b < n; b++) begin
            e.we    = st;
            e.addr  = addr + 32'(b);
            e.wdata = wdata[8*b +: 8];
            mc_q.push_back(e);
        end
    endtask

    // Byte memory: checks each request cycle against the expected queue head
    // (so a waiting request must stay stable), answers after mem_delay cycles.
    initial begin : responder
        int      waited;
        mc_exp_t e;
        mc_ready = 1'b0;
        mc_rdata = 8'h00;
        waited   = 0;
        forever begin
            @(negedge clk);
            mc_ready = 1'b0;
            if (rst && mc_req) begin
                if (mc_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected mc_req: addr 0x%08h, expected no request", mc_addr);
                end else begin
                    e = mc_q[0];
                    check("mc_we", 32'(mc_we), 32'(e.we));
                    check("mc_addr", mc_addr, e.addr);
                    if (e.we) check("mc_wdata", 32'(mc_wdata), 32'(e.wdata));
                    if (waited >= mem_delay) begin
                        void'(mc_q.pop_front());
                        if (mc_we) mem[mc_addr] = mc_wdata;
                        else       mc_rdata = mem_rd(mc_addr);
                        mc_ready = 1'b1;
                        waited   = 0;
                        hs_count++;
                    end else begin
                        waited++;
                    end
                end
            end else begin
                waited = 0;
            end
        end
    end

    task automatic drive(input logic ld, input logic st, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] alu, input logic [4:0] rd, input logic rd_en);
        ex_mem_load  = ld;
        ex_mem_store = st;
        ex_mem_op    = op;
        ex_mem_addr  = addr;
        ex_mem_wdata = wdata;
        ex_rd_data   = alu;
        ex_rd_addr   = rd;
        ex_rd_enable = rd_en;
    endtask

    // Called at the negedge of the first stalled cycle; returns at DONE's negedge.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (stall_req && cycles < 200) begin
            check("rd_enable while stalled", 32'(mem_rd_enable), 32'd0);
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin : main
        vec_t    vecs[13];
        vec_t    v;
        rd_exp_t r;
        int      cycles;
        int      n;
        int      hs0;
        logic    is_mem;

        //          ld st op     addr          wdata         alu       rd  en pre init          dly exp_data      ea  ee
        vecs[0]  = '{0, 0, LS_W,  32'h0,        32'h0,        32'h1234, 5,  1, 0, 32'h0,        0, 32'h00001234, 5,  1};
        vecs[1]  = '{1, 0, LS_W,  32'h100,      32'h0,        32'hDEAD, 7,  1, 1, 32'h12345678, 0, 32'h12345678, 7,  1};
        vecs[2]  = '{1, 0, LS_B,  32'h200,      32'h0,        32'h0,    8,  1, 1, 32'h00000080, 0, 32'hFFFFFF80, 8,  1};
        vecs[3]  = '{1, 0, LS_BU, 32'h200,      32'h0,        32'h0,    9,  1, 0, 32'h0,        1, 32'h00000080, 9,  1};
        vecs[4]  = '{1, 0, LS_H,  32'h300,      32'h0,        32'h0,    10, 1, 1, 32'h0000FF01, 1, 32'hFFFFFF01, 10, 1};
        vecs[5]  = '{1, 0, LS_HU, 32'h300,      32'h0,        32'h0,    11, 1, 0, 32'h0,        0, 32'h0000FF01, 11, 1};
        vecs[6]  = '{1, 0, LS_H,  32'h1001,     32'h0,        32'h0,    12, 1, 1, 32'h00007FFF, 0, 32'h00007FFF, 12, 1};
        vecs[7]  = '{0, 1, LS_H,  32'hFFFFFFFF, 32'hAABBCCDD, 32'h55,   13, 1, 0, 32'h0,        0, 32'h0,        0,  0};
        vecs[8]  = '{0, 1, LS_W,  32'h400,      32'hCAFEBABE, 32'h0,    0,  1, 0, 32'h0,        3, 32'h0,        0,  0};
        vecs[9]  = '{1, 0, LS_W,  32'h400,      32'h0,        32'h0,    14, 1, 0, 32'h0,        2, 32'hCAFEBABE, 14, 1};
        vecs[10] = '{1, 0, 3'b011, 32'h100,     32'h0,        32'h77,   15, 1, 0, 32'h0,        0, 32'h0,        0,  0};
        vecs[11] = '{1, 0, LS_HU, 32'hFFFFFFFF, 32'h0,        32'h0,    16, 1, 0, 32'h0,        0, 32'h0000CCDD, 16, 1};
        vecs[12] = '{0, 1, 3'b111, 32'h0,       32'h11223344, 32'h0,    17, 1, 0, 32'h0,        0, 32'h0,        0,  0};

        // Reset: outputs all zero even with a live ALU result on the inputs.
        rst = 1'b0;
        drive(1'b0, 1'b0, LS_W, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1);
        #12;
        check("reset mem_rd_data", mem_rd_data, 32'h0);
        check("reset mem_rd_enable", 32'(mem_rd_enable), 32'd0);
        check("reset stall_req", 32'(stall_req), 32'd0);
        check("reset mc_req", 32'(mc_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            if (v.preload) begin
                for (int b = 0; b < 4; b++) mem[v.addr + 32'(b)] = v.init[8*b +: 8];
            end
            mem_delay = v.delay;
            @(posedge clk);
            #1;
            drive(v.ld, v.st, v.op, v.addr, v.wdata, v.alu, v.rd, v.rd_en);
            is_mem = (v.ld || v.st) && legal(v.op);
            n = nbytes_of(v.op);
            if (is_mem) begin
                push_bytes(v.st, v.addr, v.wdata, n);
                r.data = v.exp_data;
                r.addr = v.exp_addr;
                r.en   = v.exp_en;
                rd_q.push_back(r);
            end
            @(negedge clk);
            if (!is_mem) begin
                check($sformatf("v%0d stall_req", i), 32'(stall_req), 32'd0);
                check($sformatf("v%0d mc_req", i), 32'(mc_req), 32'd0);
                check($sformatf("v%0d mem_rd_enable", i), 32'(mem_rd_enable), 32'(v.exp_en));
                if (!(v.ld || v.st)) begin
                    check($sformatf("v%0d mem_rd_data", i), mem_rd_data, v.exp_data);
                    check($sformatf("v%0d mem_rd_addr", i), 32'(mem_rd_addr), 32'(v.exp_addr));
                end
            end else begin
                wait_done(cycles);
                check($sformatf("v%0d stall cycles", i), 32'(cycles), 32'(1 + n * (v.delay + 1)));
                r = rd_q.pop_front();
                check($sformatf("v%0d done mem_rd_data", i), mem_rd_data, r.data);
                check($sformatf("v%0d done mem_rd_addr", i), 32'(mem_rd_addr), 32'(r.addr));
                check($sformatf("v%0d done mem_rd_enable", i), 32'(mem_rd_enable), 32'(r.en));
                check($sformatf("v%0d done mc_req", i), 32'(mc_req), 32'd0);
            end
        end

        // Wrapping halfword store landed on both sides of the address wrap.
        check("SH wrap byte @FFFFFFFF", 32'(mem_rd(32'hFFFFFFFF)), 32'h000000DD);
        check("SH wrap byte @00000000", 32'(mem_rd(32'h0)), 32'h000000CC);

        // Reset in the middle of a word load, after two bytes completed.
        mem[32'h500] = 8'h11;
        mem[32'h501] = 8'h22;
        mem[32'h502] = 8'h33;
        mem[32'h503] = 8'h44;
        mem_delay = 0;
        hs0 = hs_count;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, LS_W, 32'h500, 32'h0, 32'h0, 5'd20, 1'b1);
        push_bytes(1'b0, 32'h500, 32'h0, 4);
        cycles = 0;
        while (hs_count < hs0 + 2 && cycles < 50) begin
            @(posedge clk);
            cycles++;
        end
        check("bytes before reset", 32'(hs_count - hs0), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("mid-access reset mc_req", 32'(mc_req), 32'd0);
        check("mid-access reset stall_req", 32'(stall_req), 32'd0);
        check("mid-access reset mem_rd_enable", 32'(mem_rd_enable), 32'd0);
        mc_q.delete();
        drive(1'b0, 1'b0, LS_W, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, LS_W, 32'h500, 32'h0, 32'h0, 5'd21, 1'b1);
        push_bytes(1'b0, 32'h500, 32'h0, 4);
        @(negedge clk);
        wait_done(cycles);
        check("restart stall cycles", 32'(cycles), 32'd5);
        check("restart mem_rd_data", mem_rd_data, 32'h44332211);
        check("restart mem_rd_addr", 32'(mem_rd_addr), 32'd21);
        check("restart mem_rd_enable", 32'(mem_rd_enable), 32'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, LS_W, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (3) @(negedge clk);

        check("leftover mc expectations", 32'(mc_q.size()), 32'd0);
        check("leftover rd expectations", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
